// File: rtl/bcd_splitter_seq.sv
// Sequential binary-to-BCD converter (iterative double-dabble) with start/busy/done handshake.
// Digits above DIGITS are truncated; any carry out of the top digit raises overflow.
module bcd_splitter_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned SW = 4 * DIGITS + BIN_W;
  localparam int unsigned CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CntInit = CW'(BIN_W);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e        state_q;
  logic [SW-1:0] sr_q;
  logic [SW-1:0] adj;
  logic [SW-1:0] shifted;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          ovf_nxt;

  // Add-3 correction on every digit, then one left shift of the whole register.
  always_comb begin
    adj = sr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W+4*i +: 4] >= 4'd5) begin
        adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[SW-2:0], 1'b0};
    ovf_nxt = ovf_q | adj[SW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            sr_q    <= {{(4*DIGITS){1'b0}}, bin};
            cnt_q   <= CntInit;
            ovf_q   <= 1'b0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q  <= shifted;
          ovf_q <= ovf_nxt;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            bcd      <= shifted[SW-1:BIN_W];
            overflow <= ovf_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_splitter_seq.sv
// Directed bench for bcd_splitter_seq: a 3-digit and a 2-digit instance, both BIN_W=8.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_bcd_splitter_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        sel2 = 1'b0;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  logic        busy_o, done_o, ovf_o;
  logic [11:0] bcd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_splitter_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start && !sel2), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bcd_splitter_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel2), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  assign busy_o = sel2 ? busy2 : busy3;
  assign done_o = sel2 ? done2 : done3;
  assign ovf_o  = sel2 ? ovf2 : ovf3;
  assign bcd_o  = sel2 ? {4'h0, bcd2} : bcd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One full conversion on the selected instance with latency/busy/done checks.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input logic exp_ovf,
                         input string nm);
    int  busy_cnt;
    int  lat;
    bit  got;
    busy_cnt = 0;
    lat = 0;
    got = 1'b0;
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = ~v;
    if (busy_o) busy_cnt++;
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      if (done_o) begin
        got = 1'b1;
        lat = i;
      end else if (busy_o) begin
        busy_cnt++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
      return;
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency: got %0d want 8", nm, lat);
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want 8", nm, busy_cnt);
    end
    checks++;
    if (bcd_o !== exp || ovf_o !== exp_ovf || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got bcd=%h ovf=%b busy=%b want bcd=%h ovf=%b busy=0",
               nm, bcd_o, ovf_o, busy_o, exp, exp_ovf);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || bcd_o !== exp || ovf_o !== exp_ovf) begin
      errors++;
      $display("FAIL %s hold: got done=%b bcd=%h ovf=%b want done=0 bcd=%h ovf=%b",
               nm, done_o, bcd_o, ovf_o, exp, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy3, done3, bcd3, ovf3} !== 15'd0 || {busy2, done2, bcd2, ovf2} !== 11'd0) begin
      errors++;
      $display("FAIL reset: got dut3 %b%b %h %b dut2 %b%b %h %b want all zero",
               busy3, done3, bcd3, ovf3, busy2, done2, bcd2, ovf2);
    end
  endtask

  task automatic test_basic();
    sel2 = 1'b0;
    convert(8'd31, 12'h031, 1'b0, "d3_31");
    convert(8'd12, 12'h012, 1'b0, "d3_12");
    convert(8'd9, 12'h009, 1'b0, "d3_9");
    convert(8'd15, 12'h015, 1'b0, "d3_15");
    convert(8'd27, 12'h027, 1'b0, "d3_27");
    convert(8'd0, 12'h000, 1'b0, "d3_0");
    convert(8'd255, 12'h255, 1'b0, "d3_255");
  endtask

  task automatic test_overflow();
    sel2 = 1'b1;
    convert(8'd99, 12'h099, 1'b0, "d2_99");
    convert(8'd123, 12'h023, 1'b1, "d2_123");
    convert(8'd42, 12'h042, 1'b0, "d2_42_sticky_clear");
    convert(8'd200, 12'h000, 1'b1, "d2_200");
    sel2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          n_done;
    logic [11:0] got0, got1;
    int          pos0, pos1;
    n_done = 0;
    got0 = '0;
    got1 = '0;
    pos0 = 0;
    pos1 = 0;
    sel2 = 1'b0;
    bin = 8'd45;
    start = 1'b1;
    tick();
    for (int t = 1; t <= 20; t++) begin
      if (t == 3) bin = 8'd77;
      tick();
      if (done3) begin
        if (n_done == 0) begin
          got0 = bcd3;
          pos0 = t;
        end else if (n_done == 1) begin
          got1 = bcd3;
          pos1 = t;
        end
        n_done++;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 2) begin
      errors++;
      $display("FAIL b2b done count: got %0d want 2", n_done);
    end
    checks++;
    if (got0 !== 12'h045 || pos0 !== 8) begin
      errors++;
      $display("FAIL b2b first: got bcd=%h at %0d want 045 at 8", got0, pos0);
    end
    checks++;
    if (got1 !== 12'h077 || pos1 !== 17) begin
      errors++;
      $display("FAIL b2b second: got bcd=%h at %0d want 077 at 17", got1, pos1);
    end
    repeat (12) tick();
    checks++;
    if (busy3 !== 1'b0 || bcd3 !== 12'h077) begin
      errors++;
      $display("FAIL b2b drain: got busy=%b bcd=%h want busy=0 bcd=077", busy3, bcd3);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    extra = 0;
    sel2 = 1'b0;
    bin = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0
        || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b ovf2=%b want all 0",
               busy3, done3, bcd3, ovf3, ovf2);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done3 || busy3) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_mid activity: got %0d busy/done cycles want 0", extra);
    end
    convert(8'd200, 12'h200, 1'b0, "d3_200_after_rst");
  endtask

  task automatic test_sweep();
    sel2 = 1'b0;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), ref_bcd(v), 1'b0, $sformatf("sweep_%0d", v));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
